pipemem_mmio: RTL and testbench



---
 rtl/pipemem_pkg.sv | 29 ++
 rtl/pipemem_dram.sv | 27 ++
 rtl/pipemem_mmio.sv | 134 +++++++++++++
 tb/tb_pipemem_mmio.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipemem_pkg.sv
// Shared encodings, default parameters and lane helper
// for the pipelined data-memory / MMIO stage.
package pipemem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam int DEF_DMEM_AW = 5;
    localparam int DEF_N_OUT   = 3;
    localparam int DEF_N_IN    = 2;
    localparam int DEF_IO_BIT  = 7;

    // Zero result flags a misaligned or reserved-size access.
    function automatic logic [3:0] lane_en(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [3:0] be;
        case (size)
            SZ_WORD: be = (a == 2'b00) ? 4'b1111 : 4'b0000;
            SZ_HALF: be = a[0] ? 4'b0000 : (a[1] ? 4'b1100 : 4'b0011);
            SZ_BYTE: be = 4'b0001 << a;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/pipemem_dram.sv
// Single-port data RAM: byte-enabled synchronous write,
// registered read, contents never reset.
module pipemem_dram #(
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // Lane-masked write and registered read share one address.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/pipemem_mmio.sv
// Memory stage: data RAM plus distinct MMIO output
// registers and synchronised input ports.
module pipemem_mmio
    import pipemem_pkg::*;
#(
    parameter int DMEM_AW = DEF_DMEM_AW,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int N_IN    = DEF_N_IN,
    parameter int IO_BIT  = DEF_IO_BIT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              mwmem,
    input  logic              mrmem,
    input  logic [1:0]        msize,
    input  logic [31:0]       malu,
    input  logic [31:0]       mb,
    output logic [31:0]       mmo,
    output logic              mmo_valid,
    output logic [N_OUT*32-1:0] out_port,
    output logic [N_OUT-1:0]  out_stb,
    input  logic [N_IN*32-1:0]  in_port,
    output logic              io_err
);

    logic [3:0]  be;
    logic        bad_fmt;
    logic        is_io;
    logic [3:0]  idx;
    logic [31:0] wdata;
    logic        st_ok;
    logic        ld_ok;
    logic        out_hit;
    logic        err_now;
    logic [31:0] in_sel;
    logic [31:0] dram_rdata;
    logic [31:0] io_q;
    logic        src_io;
    logic        unused_addr;
    logic [31:0] out_q [N_OUT];
    logic [31:0] sync1 [N_IN];
    logic [31:0] sync2 [N_IN];

    assign be      = lane_en(msize, malu[1:0]);
    assign bad_fmt = (be == 4'b0000);
    assign is_io   = malu[IO_BIT];
    assign idx     = malu[5:2];
    assign unused_addr = ^malu;

    // Simultaneous store+load keeps the store and drops the load.
    assign st_ok   = resetn & mwmem & ~bad_fmt;
    assign ld_ok   = resetn & mrmem & ~mwmem & ~bad_fmt;
    assign out_hit = st_ok & is_io & (int'(idx) < N_OUT);
    assign err_now = ((mwmem | mrmem) & bad_fmt)
                   | (mwmem & mrmem)
                   | (st_ok & is_io & ~out_hit);

    // Replicate store data so any enabled lane sees its bytes.
    always_comb begin
        case (msize)
            SZ_BYTE: wdata = {4{mb[7:0]}};
            SZ_HALF: wdata = {2{mb[15:0]}};
            default: wdata = mb;
        endcase
    end

    // Select the synchronised input port addressed by idx.
    always_comb begin
        in_sel = 32'h0;
        for (int k = 0; k < N_IN; k++) begin
            if (idx == 4'(k)) in_sel = sync2[k];
        end
    end

    pipemem_dram #(.AW(DMEM_AW)) u_dram (
        .clock (clock),
        .we    (st_ok & ~is_io),
        .be    (be),
        .re    (ld_ok & ~is_io),
        .addr  (malu[DMEM_AW+1:2]),
        .wdata (wdata),
        .rdata (dram_rdata)
    );

    // src_io resets to 1 so mmo reads the cleared io_q.
    assign mmo = src_io ? io_q : dram_rdata;

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_port[32*g +: 32] = out_q[g];
    end

    // Two-flop synchroniser for the asynchronous inputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N_IN; k++) begin
                sync1[k] <= 32'h0;
                sync2[k] <= 32'h0;
            end
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                sync1[k] <= in_port[32*k +: 32];
                sync2[k] <= sync1[k];
            end
        end
    end

    // Load result capture, sticky error and output port writes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mmo_valid <= 1'b0;
            src_io    <= 1'b1;
            io_q      <= 32'h0;
            io_err    <= 1'b0;
            out_stb   <= '0;
            for (int k = 0; k < N_OUT; k++) out_q[k] <= 32'h0;
        end else begin
            mmo_valid <= ld_ok;
            if (ld_ok) begin
                src_io <= is_io;
                if (is_io) io_q <= in_sel;
            end
            io_err <= io_err | err_now;
            for (int k = 0; k < N_OUT; k++) begin
                out_stb[k] <= out_hit && (idx == 4'(k));
                if (out_hit && (idx == 4'(k))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) out_q[k][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipemem_mmio.sv
// Directed self-checking bench for pipemem_mmio
// with hand-computed expected values.
module tb_pipemem_mmio;

    logic        clock;
    logic        resetn;
    logic        mwmem;
    logic        mrmem;
    logic [1:0]  msize;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [31:0] mmo;
    logic        mmo_valid;
    logic [95:0] out_port;
    logic [2:0]  out_stb;
    logic [63:0] in_port;
    logic        io_err;

    int tests = 0;
    int fails = 0;

    pipemem_mmio dut (
        .clock     (clock),
        .resetn    (resetn),
        .mwmem     (mwmem),
        .mrmem     (mrmem),
        .msize     (msize),
        .malu      (malu),
        .mb        (mb),
        .mmo       (mmo),
        .mmo_valid (mmo_valid),
        .out_port  (out_port),
        .out_stb   (out_stb),
        .in_port   (in_port),
        .io_err    (io_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
        mwmem = 1'b1; mrmem = 1'b0;
        msize = sz; malu = a; mb = d;
        tick();
        mwmem = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a);
        mwmem = 1'b0; mrmem = 1'b1;
        msize = 2'b00; malu = a;
        tick();
        mrmem = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; mwmem = 1'b0; mrmem = 1'b0;
        msize = 2'b00; malu = 32'h0; mb = 32'h0;
        in_port = 64'h0;
        tick(); tick();
        chk("rst_out", {93'h0, 3'b0} | out_port, 96'h0);
        chk("rst_stb", {93'h0, out_stb}, 96'h0);
        chk("rst_mmo", {64'h0, mmo}, 96'h0);
        chk("rst_vld", {95'h0, mmo_valid}, 96'h0);
        chk("rst_err", {95'h0, io_err}, 96'h0);
        resetn = 1'b1;

        st(2'b00, 32'h04, 32'h12345678);
        ld(32'h04);
        chk("ld_vld", {95'h0, mmo_valid}, 96'h1);
        chk("ld_word", {64'h0, mmo}, {64'h0, 32'h12345678});
        tick();
        chk("idle_vld", {95'h0, mmo_valid}, 96'h0);
        chk("mmo_hold", {64'h0, mmo}, {64'h0, 32'h12345678});

        st(2'b00, 32'h04, 32'hFFFFFFFF);
        st(2'b10, 32'h06, 32'h000000AB);
        ld(32'h04);
        chk("byte_st", {64'h0, mmo}, {64'h0, 32'hFFABFFFF});
        chk("err_clr", {95'h0, io_err}, 96'h0);
        st(2'b01, 32'h05, 32'h00001234);
        chk("mis_err", {95'h0, io_err}, 96'h1);
        ld(32'h04);
        chk("mis_nowr", {64'h0, mmo}, {64'h0, 32'hFFABFFFF});

        st(2'b00, 32'h88, 32'hDEADBEEF);
        chk("io_p2", out_port, {32'hDEADBEEF, 64'h0});
        chk("io_stb", {93'h0, out_stb}, 96'h4);
        tick();
        chk("stb_1cyc", {93'h0, out_stb}, 96'h0);
        st(2'b00, 32'h8C, 32'h11111111);
        chk("oor_stb", {93'h0, out_stb}, 96'h0);
        chk("oor_out", out_port, {32'hDEADBEEF, 64'h0});
        st(2'b10, 32'h81, 32'h00000055);
        chk("io_byte", out_port, {32'hDEADBEEF, 32'h0, 32'h00005500});
        chk("io_stb0", {93'h0, out_stb}, 96'h1);

        in_port = {32'hCAFEF00D, 32'h11112222};
        tick(); tick();
        ld(32'h84);
        chk("in1_vld", {95'h0, mmo_valid}, 96'h1);
        chk("in1", {64'h0, mmo}, {64'h0, 32'hCAFEF00D});
        ld(32'h80);
        chk("in0", {64'h0, mmo}, {64'h0, 32'h11112222});
        ld(32'hBC);
        chk("in_oor", {64'h0, mmo}, 96'h0);
        chk("oor_vld", {95'h0, mmo_valid}, 96'h1);
        ld(32'h88);
        chk("no_outrd", {64'h0, mmo}, 96'h0);
        chk("err_stk", {95'h0, io_err}, 96'h1);

        st(2'b00, 32'h80, 32'h00000001);
        chk("p0_set", {64'h0, out_port[31:0]}, 96'h1);
        mrmem = 1'b1; msize = 2'b00; malu = 32'h04;
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_vld", {95'h0, mmo_valid}, 96'h0);
        chk("ar_p0", {64'h0, out_port[31:0]}, 96'h0);
        chk("ar_err", {95'h0, io_err}, 96'h0);
        chk("ar_mmo", {64'h0, mmo}, 96'h0);
        tick();
        chk("ar_ldrop", {95'h0, mmo_valid}, 96'h0);
        mrmem = 1'b0;
        resetn = 1'b1;
        ld(32'h04);
        chk("retain", {64'h0, mmo}, {64'h0, 32'hFFABFFFF});

        mwmem = 1'b1; mrmem = 1'b1; msize = 2'b00;
        malu = 32'h08; mb = 32'h0BADF00D;
        tick();
        mwmem = 1'b0; mrmem = 1'b0;
        chk("both_vld", {95'h0, mmo_valid}, 96'h0);
        chk("both_err", {95'h0, io_err}, 96'h1);
        ld(32'h08);
        chk("both_st", {64'h0, mmo}, {64'h0, 32'h0BADF00D});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
